// File: rtl/uart_fifo_if.sv
// ============================================================================
//  Module      : uart_fifo_if
//  Description : Push/pop and status bundle for the show-ahead byte FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_fifo_if #(
    parameter int B = 8,
    parameter int W = 4
);
    logic         wr;
    logic [B-1:0] w_data;
    logic         rd;
    logic [B-1:0] r_data;
    logic         empty;
    logic         full;
    logic [W:0]   count;
    logic         overflow;
    logic         underflow;
    logic         clr_err;

    modport master (
        output wr, w_data, rd, clr_err,
        input  r_data, empty, full, count, overflow, underflow
    );

    modport slave (
        input  wr, w_data, rd, clr_err,
        output r_data, empty, full, count, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
//  Module      : uart_fifo
//  Description : Synchronous show-ahead byte FIFO with sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    uart_fifo_if.slave  bus
);
    localparam int unsigned c_depth = 2 ** W;

    logic [B-1:0] mem_q [c_depth];
    logic [W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic w_rd_ok;
    logic w_wr_ok;
    logic w_ovf_set;
    logic w_unf_set;

    // A pop on the same edge frees a slot, so a write into a full FIFO is legal with rd.
    assign w_rd_ok   = bus.rd & ~empty_q;
    assign w_wr_ok   = bus.wr & (~full_q | bus.rd);
    assign w_ovf_set = bus.wr & full_q & ~bus.rd;
    assign w_unf_set = bus.rd & empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        empty_d  = empty_q;
        full_d   = full_q;
        if (w_wr_ok && !w_rd_ok) begin
            wr_ptr_d = wr_ptr_q + W'(1);
            count_d  = count_q + (W+1)'(1);
            empty_d  = 1'b0;
            full_d   = (count_q == (W+1)'(c_depth - 1));
        end else if (!w_wr_ok && w_rd_ok) begin
            rd_ptr_d = rd_ptr_q + W'(1);
            count_d  = count_q - (W+1)'(1);
            full_d   = 1'b0;
            empty_d  = (count_q == (W+1)'(1));
        end else if (w_wr_ok && w_rd_ok) begin
            wr_ptr_d = wr_ptr_q + W'(1);
            rd_ptr_d = rd_ptr_q + W'(1);
        end
        // A new error on the clearing edge wins over the clear.
        ovf_d = w_ovf_set | (ovf_q & ~bus.clr_err);
        unf_d = w_unf_set | (unf_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem_q[wr_ptr_q] <= bus.w_data;
        end
    end

    assign bus.r_data    = mem_q[rd_ptr_q];
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

`default_nettype wire
